fifo_lookahead_adapter: RTL and testbench

Downstream consumer of the non-lookahead `fifo`, where read data appears on `dout` the cycle after `rd` is accepted.
- Issues reads to that FIFO and captures the returned words into a 3-entry prefetch buffer.
- Presents them as a first-word-fall-through valid/ready stream.
- `fifo_rd` depends only on internal state and `fifo_empty`, never on `o_ready`, so there is no combinational path across the boundary. Sustains one word per cycle.

---
 rtl/fifo_lookahead_adapter.sv | 68 ++++++
 tb/tb_fifo_lookahead_adapter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_lookahead_adapter.sv
// Lookahead adapter for a registered-output FIFO: prefetches up to three words
// and presents them as a first-word-fall-through valid/ready stream.
module fifo_lookahead_adapter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  flush,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_count
);

   logic [1:0]            count, rd_ptr, wr_ptr;
   logic                  pending, pop, capture;
   logic [2:0]            committed;
   logic [DATA_WIDTH-1:0] mem [3];

   function automatic logic [1:0] inc3(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Buffered plus in-flight words; a read is only issued when a slot is guaranteed,
   // so the read request never looks at o_ready.
   assign committed = {1'b0, count} + {2'b00, pending};
   assign fifo_rd   = rst & ~fifo_empty & ~flush & (committed <= 3'd2);
   assign o_valid   = (count != 2'd0);
   assign pop       = o_valid & o_ready & ~flush;
   assign capture   = pending & ~flush;
   assign o_data    = mem[rd_ptr];
   assign o_count   = count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= 2'd0;
         pending <= 1'b0;
         rd_ptr  <= 2'd0;
         wr_ptr  <= 2'd0;
      end else if (flush) begin
         count   <= 2'd0;
         pending <= 1'b0;
         rd_ptr  <= 2'd0;
         wr_ptr  <= 2'd0;
      end else begin
         pending <= fifo_rd;
         if (capture) wr_ptr <= inc3(wr_ptr);
         if (pop)     rd_ptr <= inc3(rd_ptr);
         count <= count + {1'b0, capture} - {1'b0, pop};
      end
   end

   // Storage is cleared on reset so o_data reads zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) mem[i] <= '0;
      end else if (capture) begin
         mem[wr_ptr] <= fifo_dout;
      end
   end

   assert property (@(posedge clk) disable iff (!rst)
      !(count == 2'd3 && capture && !pop));

endmodule

// File: tb/tb_fifo_lookahead_adapter.sv
// Scoreboard bench: a queue-based upstream FIFO model feeds the adapter; a negedge
// monitor checks handshake, count and data order against the queued expectations.
module tb_fifo_lookahead_adapter;

   logic        clk, rst, fifo_empty, fifo_rd, flush, o_valid, o_ready;
   logic [31:0] fifo_dout, o_data;
   logic [1:0]  o_count;

   fifo_lookahead_adapter #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
      .fifo_dout(fifo_dout), .flush(flush), .o_valid(o_valid), .o_ready(o_ready),
      .o_data(o_data), .o_count(o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0, bad = 0, cyc = 0, npop = 0;
   logic [31:0] up_q[$];   // contents of the upstream FIFO
   logic [31:0] exp_q[$];  // every word written upstream and not yet popped or discarded
   int          rd_cyc[$]; // cycle of each accepted read not yet popped or discarded
   logic        s_acc = 1'b0, s_flush = 1'b0;
   int          m_cap;
   logic        m_ev;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // A word read in cycle t is visible on the stream from cycle t+2.
   function automatic int captured();
      int n = 0;
      foreach (rd_cyc[i]) if (rd_cyc[i] <= cyc - 2) n++;
      return n;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         m_cap = captured();
         m_ev  = (m_cap != 0);
         chk("fifo_rd", fifo_rd, !fifo_empty && !flush && rd_cyc.size() <= 2);
         chk("o_count", o_count, m_cap);
         chk("o_valid", o_valid, m_ev);
         if (m_ev) chk("o_data", o_data, exp_q[0]);
         if (m_ev && o_ready && !flush) begin
            void'(exp_q.pop_front());
            void'(rd_cyc.pop_front());
            npop++;
         end
         s_acc   = fifo_rd && !fifo_empty;
         s_flush = flush;
      end
   end

   task automatic put(input logic [31:0] w);
      up_q.push_back(w);
      exp_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (s_flush) begin
         repeat (rd_cyc.size()) void'(exp_q.pop_front());
         rd_cyc.delete();
      end
      if (s_acc) begin
         fifo_dout = up_q.pop_front();
         rd_cyc.push_back(cyc - 1);
      end else begin
         fifo_dout = $urandom;
      end
      s_acc      = 1'b0;
      s_flush    = 1'b0;
      fifo_empty = (up_q.size() == 0);
   endtask

   logic [31:0] pat [8] = '{32'h5A, 32'hF6, 32'h09, 32'hC4, 32'h81, 32'hE2, 32'hA0, 32'h7A};

   initial begin
      int p;
      bit done;
      rst = 1'b0; fifo_empty = 1'b0; flush = 1'b0; o_ready = 1'b0; fifo_dout = '0;
      #2;
      chk("reset_fifo_rd", fifo_rd, 0);
      chk("reset_o_valid", o_valid, 0);
      chk("reset_o_count", o_count, 0);
      chk("reset_o_data", o_data, 0);
      fifo_empty = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // streaming without backpressure
      p = npop;
      o_ready = 1'b1;
      foreach (pat[i]) put(pat[i]);
      repeat (15) step();
      chk("stream_pops", npop - p, 8);

      // backpressure, then release across pointer wrap
      p = npop;
      o_ready = 1'b0;
      foreach (pat[i]) put(pat[i]);
      repeat (10) step();
      chk("stall_count", o_count, 3);
      chk("stall_head", o_data, 32'h5A);
      o_ready = 1'b1;
      repeat (15) step();
      chk("bp_pops", npop - p, 8);

      // single word then idle upstream
      p = npop;
      put(32'hC4);
      repeat (22) step();
      chk("idle_pops", npop - p, 1);
      chk("idle_valid", o_valid, 0);

      // flush with two buffered words and one read in flight
      p = npop;
      o_ready = 1'b0;
      for (int i = 0; i < 6; i++) put(32'h100 + i);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (captured() == 2 && rd_cyc.size() == 3) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            done  = 1'b1;
         end else begin
            step();
         end
      end
      chk("flush_setup", done, 1);
      chk("flush_count", o_count, 0);
      chk("flush_valid", o_valid, 0);
      o_ready = 1'b1;
      repeat (12) step();
      chk("flush_pops", npop - p, 3);
      chk("flush_drain", exp_q.size(), 0);

      // asynchronous reset with two words buffered
      o_ready = 1'b0;
      for (int i = 0; i < 4; i++) put(32'h200 + i);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (captured() == 2) done = 1'b1;
         else step();
      end
      chk("rst_setup", o_count, 2);
      #2 rst = 1'b0;
      up_q.delete(); exp_q.delete(); rd_cyc.delete();
      s_acc = 1'b0; s_flush = 1'b0;
      #1;
      chk("async_fifo_rd", fifo_rd, 0);
      chk("async_o_valid", o_valid, 0);
      chk("async_o_count", o_count, 0);
      fifo_empty = 1'b1;
      #2 rst = 1'b1;
      p = npop;
      step();
      o_ready = 1'b1;
      put(32'h300); put(32'h301);
      repeat (8) step();
      chk("post_rst_pops", npop - p, 2);

      // random traffic and random ready
      p = npop;
      begin
         int wrote = 0;
         done = 1'b0;
         for (int i = 0; i < 20000 && !done; i++) begin
            if (wrote < 1024 && $urandom_range(1) == 1) begin
               put({24'h0, 8'($urandom_range(255))});
               wrote++;
            end
            o_ready = ($urandom_range(2) == 0);
            step();
            if (wrote == 1024 && exp_q.size() == 0) done = 1'b1;
         end
      end
      chk("random_drained", done, 1);
      chk("random_pops", npop - p, 1024);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
